// File: rtl/cpt_sched_if.sv
// Bundle between the counter scheduler, its requesters and the shared counter.
// The master side drives requests, targets and the counter value; the slave side is the scheduler.
interface cpt_sched_if #(
    parameter int WIDTH = 3,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] target;
    logic [WIDTH-1:0]      cnt_val;
    logic                  cnt_clear;
    logic                  cnt_activate;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic                  busy;

    modport master (
        output req, target, cnt_val,
        input  cnt_clear, cnt_activate, grant, done, busy
    );

    modport slave (
        input  req, target, cnt_val,
        output cnt_clear, cnt_activate, grant, done, busy
    );
endinterface

// File: rtl/cpt_sched.sv
// Round-robin owner of a shared up-counter: grants, clears, runs to the owner's target, pulses done.
//
//   state    | meaning
//   IDLE     | no owner; pick next requester after the round-robin pointer
//   CLEAR    | owner granted; counter cleared this cycle
//   RUN      | counter enabled while below the latched target
//   DONE     | one-cycle done pulse to the owner; grant still held
module cpt_sched #(
    parameter int WIDTH = 3,
    parameter int NREQ  = 4
) (
    input logic        clk,
    input logic        reset,
    cpt_sched_if.slave bus
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [IDXW-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] tgt_arr [NREQ];
    logic             pick_vld;
    logic [IDXW-1:0]  pick_idx;
    logic             own_req;
    logic             at_target;

    for (genvar g = 0; g < NREQ; g++) begin : g_tgt
        assign tgt_arr[g] = bus.target[g*WIDTH +: WIDTH];
    end

    // Scan from farthest to nearest so the candidate closest after the pointer wins.
    always_comb begin
        int c;
        c        = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            c = (int'(ptr_q) + k) % NREQ;
            if (bus.req[IDXW'(c)]) begin
                pick_vld = 1'b1;
                pick_idx = IDXW'(c);
            end
        end
    end

    assign own_req   = bus.req[idx_q];
    assign at_target = (bus.cnt_val >= tgt_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        tgt_d   = tgt_q;
        grant_d = grant_q;
        done_d  = '0;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (pick_vld) begin
                    idx_d   = pick_idx;
                    tgt_d   = tgt_arr[pick_idx];
                    grant_d = NREQ'(1) << pick_idx;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (!own_req) begin
                    grant_d = '0;
                    ptr_d   = idx_q;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A withdrawn owner loses the counter even if it hit its target this cycle.
                if (!own_req) begin
                    grant_d = '0;
                    ptr_d   = idx_q;
                    state_d = ST_IDLE;
                end else if (at_target) begin
                    done_d  = grant_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                grant_d = '0;
                ptr_d   = idx_q;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            ptr_q   <= IDXW'(NREQ - 1);
            tgt_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            tgt_q   <= tgt_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.done         = done_q;
    assign bus.busy         = busy_q;
    assign bus.cnt_clear    = (state_q == ST_CLEAR);
    assign bus.cnt_activate = (state_q == ST_RUN) && own_req && !at_target;
endmodule

// File: doc/cpt_sched.md
Name: cpt_sched

Overview:
- Round-robin scheduler that shares one external bit counter (WIDTH bits, activate/clear interface) among NREQ requesters.
- Each requester asks for a count run to its own target value.
- The block grants the counter to one requester, clears it, enables counting until the target is reached, pulses done to the owner, then moves to the next requester.
- Sits between the requester logic and the shared counter instance in the compteur area.

Parameters:
- WIDTH, 3, counter width in bits; each target is WIDTH bits.
- NREQ, 4, number of requesters (2..8).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester request level; held until done or withdrawn.
- target  input  NREQ*WIDTH  packed targets; requester i uses bits [i*WIDTH +: WIDTH]; sampled at grant.
- cnt_val  input  WIDTH  current value of the shared counter.
- cnt_clear  output  1  synchronous clear request to the counter.
- cnt_activate  output  1  count-enable to the counter (+1 per clk while high).
- grant  output  NREQ  one-hot owner of the counter, or all zero.
- done  output  NREQ  one-cycle completion pulse to the owner.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - grant=0, done=0, busy=0, cnt_clear=0, cnt_activate=0.
  - Latched index and target are cleared.
  - Round-robin pointer goes to NREQ-1, so requester 0 has first priority.
  - Reset mid-run abandons the run with no done pulse.
- Outputs:
  - grant, done and busy are registered.
  - cnt_clear and cnt_activate are decoded from the state registers plus cnt_val.
- State IDLE:
  - If req is nonzero, select the first asserted requester searching from pointer+1 upward, with modulo NREQ wrap.
  - Latch its index and target, set grant[idx], go to CLEAR.
  - If req is zero, stay in IDLE.
- State CLEAR (one cycle):
  - cnt_clear=1, cnt_activate=0; go to RUN.
- State RUN:
  - cnt_activate = (cnt_val < latched target).
  - When cnt_val >= target, go to DONE on the next edge. Using >= means an overshooting counter still terminates.
- State DONE (one cycle):
  - done[idx]=1; grant stays asserted.
  - Next edge: grant=0, done=0, pointer=idx, go to IDLE.
- Withdrawal: if req[idx] drops during CLEAR or RUN:
  - Go to IDLE on the next edge with grant=0 and no done pulse.
  - Pointer is set to idx.
  - cnt_activate is forced to 0 in the cycle req[idx] is observed low.
- Latency:
  - grant rises at edge e0 (req sampled in IDLE).
  - Counter cleared at e1; increments at e2..e(T+1).
  - done is high from e(T+2) to e(T+3).
  - Next grant is possible at e(T+4), because IDLE takes one cycle.
- Target 0: RUN lasts one cycle with cnt_activate=0; done still rises at e2.
- Target 2^WIDTH-1: counting stops at the maximum value; the counter never wraps under this control.
- Target changes after grant are ignored; req changes of non-owners are ignored until IDLE.
- Fairness: a requester that holds req after its done is served again only after all other pending requesters.
- Invariants:
  - At most one grant bit set.
  - done is a subset of grant.
  - cnt_activate and cnt_clear are never high together.
  - cnt_activate=0 whenever grant=0.

Test Plan:
- Reset then single request: req=0001, target0=4 -> grant=0001 at e0; cnt_clear high e0..e1; cnt_activate high for 4 cycles; cnt_val=4; done=0001 one cycle at e6; busy=0 after e7.
- Round-robin with all requests: req=1111 held continuously, targets 1,2,3,0 -> grant order 0,1,2,3,0; each done lands at T+2 after its grant; never two grant bits set.
- Pointer fairness: requester 2 served, then req=0101 -> requester 0 granted, not requester 2 re-served first, since the search runs from 3 and wraps to 0.
- Boundaries: target=0 -> done at e2 with cnt_activate never asserted; target=7 (WIDTH=3) -> cnt_val stops at 7 without wrap, done at e9.
- Withdrawal: req[1] drops when cnt_val=2 of target 5 -> cnt_activate=0 that cycle; IDLE next edge; no done; next pending requester granted.
- Asynchronous reset mid-RUN: reset=0 between edges -> all outputs 0 immediately; after release, req=1000 -> requester 3 granted only if requester 0 is not requesting.
